// File: rtl/obstacle_field_gen.sv
// obstacle_field_gen: runner game-state producer; in CLK, RST (sync, active-high), START, BTN_JUMP; out obstacle[15:0], jump, game_over, score[13:0]
module obstacle_field_gen #(
    parameter int          TICK_DIV   = 25000000,
    parameter int          JUMP_TICKS = 3,
    parameter int          GAP_MIN    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        BTN_JUMP,
    output logic [15:0] obstacle,
    output logic        jump,
    output logic        game_over,
    output logic [13:0] score
);
    localparam int TW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]   obstacle_q, obstacle_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [13:0]   score_q, score_d;
    logic [3:0]    air_cnt_q, air_cnt_d;
    logic [2:0]    gap_cnt_q, gap_cnt_d;
    logic          jump_q, jump_d;
    logic [2:0]    sync_q, sync_d;
    logic          tick, btn_edge, hit, fb;
    logic [1:0]    new_cell;
    always_comb begin
        sync_d     = {sync_q[1:0], BTN_JUMP};
        btn_edge   = sync_q[1] & ~sync_q[2];
        hit        = (obstacle_q[15:14] == 2'b01 && !jump_q) || (obstacle_q[15:14] == 2'b10 && jump_q);
        tick       = tick_cnt_q == TW'(TICK_DIV - 1);
        fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        new_cell   = |gap_cnt_q ? 2'b00 : (lfsr_q[1:0] == 2'b11 ? 2'b00 : lfsr_q[1:0]);
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        obstacle_d = obstacle_q;
        lfsr_d     = lfsr_q;
        score_d    = score_q;
        air_cnt_d  = air_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        jump_d     = jump_q;
        case (state_q)
            IDLE, OVER: begin
                if (START) begin
                    state_d    = RUN;
                    tick_cnt_d = '0;
                    obstacle_d = '0;
                    score_d    = '0;
                    air_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    jump_d     = 1'b0;
                end
            end
            RUN: begin
                if (hit) begin
                    state_d = OVER;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                    if (tick) begin
                        obstacle_d = {obstacle_q[13:0], new_cell};
                        lfsr_d     = lfsr_q == '0 ? LFSR_SEED : {lfsr_q[14:0], fb};
                        score_d    = score_q == 14'd9999 ? score_q : score_q + 14'd1;
                        gap_cnt_d  = |gap_cnt_q ? gap_cnt_q - 3'd1 : (|new_cell ? 3'(GAP_MIN) : 3'd0);
                        if (|air_cnt_q) begin
                            air_cnt_d = air_cnt_q - 4'd1;
                            jump_d    = air_cnt_q != 4'd1;
                        end
                    end
                    // a fresh jump overrides the same-cycle airborne decrement
                    if (btn_edge && !jump_q) begin
                        jump_d    = 1'b1;
                        air_cnt_d = 4'(JUMP_TICKS);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            obstacle_q <= '0;
            lfsr_q     <= LFSR_SEED;
            score_q    <= '0;
            air_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            jump_q     <= 1'b0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            obstacle_q <= obstacle_d;
            lfsr_q     <= lfsr_d;
            score_q    <= score_d;
            air_cnt_q  <= air_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            jump_q     <= jump_d;
            sync_q     <= sync_d;
        end
    end
    assign obstacle  = obstacle_q;
    assign jump      = jump_q;
    assign score     = score_q;
    assign game_over = state_q == OVER;
endmodule

// File: tb/tb_obstacle_field_gen.sv
// tb_obstacle_field_gen: directed self-checking bench for obstacle_field_gen
module tb_obstacle_field_gen;
    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, BTN_JUMP = 1'b0;
    logic        start_b = 1'b0, btn_b = 1'b0;
    logic [15:0] obstacle, obstacle_b;
    logic        jump, jump_b, game_over, game_over_b;
    logic [13:0] score, score_b;
    int          checks = 0, passed = 0;
    always #5 CLK = ~CLK;
    obstacle_field_gen #(.TICK_DIV(4), .JUMP_TICKS(3), .GAP_MIN(2), .LFSR_SEED(16'hACE1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BTN_JUMP(BTN_JUMP),
        .obstacle(obstacle), .jump(jump), .game_over(game_over), .score(score)
    );
    obstacle_field_gen #(.TICK_DIV(2), .JUMP_TICKS(2), .GAP_MIN(7), .LFSR_SEED(16'hACE1)) dut_b (
        .CLK(CLK), .RST(RST), .START(start_b), .BTN_JUMP(btn_b),
        .obstacle(obstacle_b), .jump(jump_b), .game_over(game_over_b), .score(score_b)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic check_all(input string tag, input logic [15:0] obs, input logic jmp, input logic go, input logic [13:0] sc);
        check({tag, ".obstacle"}, 32'(obstacle), 32'(obs));
        check({tag, ".jump"}, 32'(jump), 32'(jmp));
        check({tag, ".game_over"}, 32'(game_over), 32'(go));
        check({tag, ".score"}, 32'(score), 32'(sc));
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask
    initial begin
        cyc(2);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            BTN_JUMP = i >= 5 && i < 10;
            cyc(1);
            check_all("idle", 16'h0000, 1'b0, 1'b0, 14'd0);
        end
        START = 1'b1;
        cyc(1);
        START = 1'b0;
        cyc(3);
        check_all("g1_pre_tick", 16'h0000, 1'b0, 1'b0, 14'd0);
        cyc(1);
        check_all("g1_t1", 16'h0001, 1'b0, 1'b0, 14'd1);
        cyc(4);
        check_all("g1_t2", 16'h0004, 1'b0, 1'b0, 14'd2);
        cyc(1);
        START = 1'b1;
        cyc(1);
        START = 1'b0;
        cyc(2);
        check_all("g1_t3_start_ignored", 16'h0010, 1'b0, 1'b0, 14'd3);
        cyc(4);
        check_all("g1_t4", 16'h0040, 1'b0, 1'b0, 14'd4);
        cyc(4);
        check_all("g1_t5", 16'h0102, 1'b0, 1'b0, 14'd5);
        cyc(12);
        check_all("g1_t8", 16'h4082, 1'b0, 1'b0, 14'd8);
        cyc(1);
        check_all("g1_hit", 16'h4082, 1'b0, 1'b1, 14'd8);
        for (int i = 0; i < 50; i++) begin
            BTN_JUMP = i >= 10 && i < 15;
            cyc(1);
            check_all("g1_over_hold", 16'h4082, 1'b0, 1'b1, 14'd8);
        end
        START = 1'b1;
        cyc(1);
        START = 1'b0;
        check_all("g2_restart", 16'h0000, 1'b0, 1'b0, 14'd0);
        cyc(35);
        BTN_JUMP = 1'b1;
        cyc(1);
        check_all("g2_t9", 16'h1081, 1'b0, 1'b0, 14'd9);
        cyc(1);
        check("g2_jump_2nd_edge", 32'(jump), 32'd0);
        cyc(1);
        check("g2_jump_3rd_edge", 32'(jump), 32'd1);
        cyc(1);
        BTN_JUMP = 1'b0;
        cyc(1);
        check_all("g2_t10_airborne", 16'h4204, 1'b1, 1'b0, 14'd10);
        cyc(1);
        check("g2_survived", 32'(game_over), 32'd0);
        cyc(1);
        BTN_JUMP = 1'b1;
        cyc(2);
        check_all("g2_t11", 16'h0810, 1'b1, 1'b0, 14'd11);
        cyc(2);
        BTN_JUMP = 1'b0;
        cyc(1);
        check("g2_still_air", 32'(jump), 32'd1);
        cyc(1);
        check_all("g2_t12_land", 16'h2042, 1'b0, 1'b0, 14'd12);
        cyc(1);
        BTN_JUMP = 1'b1;
        cyc(3);
        check_all("g2_t13_jump_on_tick", 16'h8108, 1'b1, 1'b0, 14'd13);
        cyc(1);
        BTN_JUMP = 1'b0;
        check_all("g2_overhead_hit", 16'h8108, 1'b1, 1'b1, 14'd13);
        cyc(5);
        check_all("g2_over_hold", 16'h8108, 1'b1, 1'b1, 14'd13);
        START = 1'b1;
        cyc(1);
        START = 1'b0;
        check_all("g3_restart", 16'h0000, 1'b0, 1'b0, 14'd0);
        cyc(4);
        check_all("g3_t1_no_reseed", 16'h0000, 1'b0, 1'b0, 14'd1);
        cyc(8);
        check_all("g3_t3", 16'h0002, 1'b0, 1'b0, 14'd3);
        cyc(3);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        check_all("rst_on_tick", 16'h0000, 1'b0, 1'b0, 14'd0);
        cyc(10);
        check_all("rst_idle", 16'h0000, 1'b0, 1'b0, 14'd0);
        START = 1'b1;
        cyc(1);
        START = 1'b0;
        cyc(4);
        check_all("g4_t1_reseeded", 16'h0001, 1'b0, 1'b0, 14'd1);
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        for (int n = 1; n <= 20100; n++) begin
            cyc(1);
            btn_b = n % 2 == 0 && obstacle_b[11:10] == 2'b01;
            if (n == 19996) check("sat_9998", 32'(score_b), 32'd9998);
            if (n == 19998) check("sat_9999", 32'(score_b), 32'd9999);
        end
        check("sat_hold", 32'(score_b), 32'd9999);
        check("sat_alive", 32'(game_over_b), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
